// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: computes the real outcome/target of jal, jalr and B-type
// instructions, detects mispredicts and issues a registered PC redirect plus pipeline flushes.
module branch_resolve_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_valid,
    input  logic [6:0]       ex_opcode,
    input  logic [2:0]       ex_funct3,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic [XLEN-1:0]  ex_imm,
    input  logic [XLEN-1:0]  ex_rs1,
    input  logic [XLEN-1:0]  ex_rs2,
    input  logic             ex_pred_taken,
    input  logic [XLEN-1:0]  ex_pred_pc,
    input  logic             redirect_ready,
    output logic             redirect_valid,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             misalign_err,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] miss_cnt
);

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_REDIR = 1'b1;

    localparam logic [XLEN-1:0]  PC_STEP = {{(XLEN-3){1'b0}}, 3'd4};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [0:0]       state_q, state_d;
    logic [XLEN-1:0]  redirect_pc_q, redirect_pc_d;
    logic             misalign_q, misalign_d;
    logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

    logic             is_cf_s;
    logic             taken_s;
    logic [XLEN-1:0]  target_s;
    logic [XLEN-1:0]  next_pc_s;
    logic             accept_s;
    logic             mispredict_s;

    // Resolve actual direction and target of the EX instruction
    always_comb begin
        is_cf_s  = 1'b0;
        taken_s  = 1'b0;
        target_s = ex_pc + ex_imm;
        case (ex_opcode)
            OP_JAL: begin
                is_cf_s = 1'b1;
                taken_s = 1'b1;
            end
            OP_JALR: begin
                is_cf_s  = 1'b1;
                taken_s  = 1'b1;
                target_s = (ex_rs1 + ex_imm) & ~{{(XLEN-1){1'b0}}, 1'b1};
            end
            OP_BRANCH: begin
                is_cf_s = 1'b1;
                case (ex_funct3)
                    3'b000:  taken_s = (ex_rs1 == ex_rs2);
                    3'b001:  taken_s = (ex_rs1 != ex_rs2);
                    3'b100:  taken_s = ($signed(ex_rs1) <  $signed(ex_rs2));
                    3'b101:  taken_s = ($signed(ex_rs1) >= $signed(ex_rs2));
                    3'b110:  taken_s = (ex_rs1 <  ex_rs2);
                    3'b111:  taken_s = (ex_rs1 >= ex_rs2);
                    default: taken_s = 1'b0;
                endcase
            end
            default: begin
                is_cf_s = 1'b0;
                taken_s = 1'b0;
            end
        endcase
        next_pc_s = taken_s ? target_s : (ex_pc + PC_STEP);
    end

    // Wrong-path instructions arriving while a redirect is pending are never accepted
    assign accept_s     = ex_valid && (state_q == ST_IDLE);
    assign mispredict_s = accept_s &&
                          ((taken_s != ex_pred_taken) || (taken_s && (target_s != ex_pred_pc)));

    // Next-state: redirect FSM, misalign pulse and saturating counters
    always_comb begin
        state_d       = state_q;
        redirect_pc_d = redirect_pc_q;
        misalign_d    = accept_s && taken_s && target_s[1];
        br_cnt_d      = br_cnt_q;
        miss_cnt_d    = miss_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (mispredict_s) begin
                    state_d       = ST_REDIR;
                    redirect_pc_d = next_pc_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REDIR: begin
                if (redirect_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_REDIR;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (accept_s && is_cf_s && (br_cnt_q != CNT_MAX)) begin
            br_cnt_d = br_cnt_q + CNT_ONE;
        end else begin
            br_cnt_d = br_cnt_q;
        end
        if (mispredict_s && (miss_cnt_q != CNT_MAX)) begin
            miss_cnt_d = miss_cnt_q + CNT_ONE;
        end else begin
            miss_cnt_d = miss_cnt_q;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            redirect_pc_q <= {XLEN{1'b0}};
            misalign_q    <= 1'b0;
            br_cnt_q      <= {CNT_W{1'b0}};
            miss_cnt_q    <= {CNT_W{1'b0}};
        end else begin
            state_q       <= state_d;
            redirect_pc_q <= redirect_pc_d;
            misalign_q    <= misalign_d;
            br_cnt_q      <= br_cnt_d;
            miss_cnt_q    <= miss_cnt_d;
        end
    end

    assign redirect_valid = (state_q == ST_REDIR);
    assign flush_if_id    = (state_q == ST_REDIR);
    assign flush_id_ex    = (state_q == ST_REDIR);
    assign redirect_pc    = redirect_pc_q;
    assign misalign_err   = misalign_q;
    assign br_cnt         = br_cnt_q;
    assign miss_cnt       = miss_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed self-checking bench for branch_resolve_unit; a second narrow-counter instance
// shares the stimulus so counter saturation is reachable in a short run.
module tb_branch_resolve_unit;

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_ADD    = 7'b0110011;

    logic        clk;
    logic        rst;
    logic        ex_valid;
    logic [6:0]  ex_opcode;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_pc, ex_imm, ex_rs1, ex_rs2, ex_pred_pc;
    logic        ex_pred_taken;
    logic        redirect_ready;

    logic        redirect_valid, flush_if_id, flush_id_ex, misalign_err;
    logic [31:0] redirect_pc, br_cnt, miss_cnt;

    logic        sm_redirect_valid, sm_flush_if_id, sm_flush_id_ex, sm_misalign_err;
    logic [31:0] sm_redirect_pc;
    logic [2:0]  sm_br_cnt, sm_miss_cnt;

    int n_chk;
    int n_fail;

    branch_resolve_unit #(.XLEN(32), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_funct3(ex_funct3),
        .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_pred_taken(ex_pred_taken), .ex_pred_pc(ex_pred_pc), .redirect_ready(redirect_ready),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush_if_id(flush_if_id),
        .flush_id_ex(flush_id_ex), .misalign_err(misalign_err), .br_cnt(br_cnt), .miss_cnt(miss_cnt)
    );

    branch_resolve_unit #(.XLEN(32), .CNT_W(3)) dut_sm (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_funct3(ex_funct3),
        .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_pred_taken(ex_pred_taken), .ex_pred_pc(ex_pred_pc), .redirect_ready(redirect_ready),
        .redirect_valid(sm_redirect_valid), .redirect_pc(sm_redirect_pc), .flush_if_id(sm_flush_if_id),
        .flush_id_ex(sm_flush_id_ex), .misalign_err(sm_misalign_err), .br_cnt(sm_br_cnt),
        .miss_cnt(sm_miss_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [6:0] op, input logic [2:0] f3,
                         input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] rs1,
                         input logic [31:0] rs2, input logic pt, input logic [31:0] ppc);
        ex_valid      = v;
        ex_opcode     = op;
        ex_funct3     = f3;
        ex_pc         = pc;
        ex_imm        = imm;
        ex_rs1        = rs1;
        ex_rs2        = rs2;
        ex_pred_taken = pt;
        ex_pred_pc    = ppc;
    endtask

    task automatic idle_in();
        drive(1'b0, 7'b0000000, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        redirect_ready = 1'b1;
        idle_in();
        tick();
        tick();
        rst = 1'b0;
        n_chk++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rv got %0h want 0", redirect_valid); end
        n_chk++; if (redirect_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc got %0h want 0", redirect_pc); end
        n_chk++; if ({flush_if_id, flush_id_ex, misalign_err} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %0b want 000", {flush_if_id, flush_id_ex, misalign_err}); end
        n_chk++; if ({br_cnt, miss_cnt} !== 64'h0) begin n_fail++; $display("FAIL reset_cnt got %0h/%0h want 0/0", br_cnt, miss_cnt); end
    endtask

    task automatic test_beq_mispredict();
        drive(1'b1, OP_BRANCH, 3'b000, 32'h100, 32'h20, 32'd5, 32'd5, 1'b0, 32'h104);
        tick();
        idle_in();
        n_chk++; if (redirect_valid !== 1'b1) begin n_fail++; $display("FAIL beq_rv got %0h want 1", redirect_valid); end
        n_chk++; if (redirect_pc !== 32'h120) begin n_fail++; $display("FAIL beq_pc got %0h want 120", redirect_pc); end
        n_chk++; if ({flush_if_id, flush_id_ex} !== 2'b11) begin n_fail++; $display("FAIL beq_flush got %0b want 11", {flush_if_id, flush_id_ex}); end
        n_chk++; if (miss_cnt !== 32'd1 || br_cnt !== 32'd1) begin n_fail++; $display("FAIL beq_cnt got %0d/%0d want 1/1", br_cnt, miss_cnt); end
        tick();
        n_chk++; if ({redirect_valid, flush_if_id, flush_id_ex} !== 3'b000) begin n_fail++; $display("FAIL beq_release got %0b want 000", {redirect_valid, flush_if_id, flush_id_ex}); end
    endtask

    task automatic test_bne_not_taken();
        drive(1'b1, OP_BRANCH, 3'b001, 32'h100, 32'h20, 32'd5, 32'd5, 1'b0, 32'h104);
        tick();
        idle_in();
        n_chk++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL bne_rv got %0h want 0", redirect_valid); end
        n_chk++; if (br_cnt !== 32'd2 || miss_cnt !== 32'd1) begin n_fail++; $display("FAIL bne_cnt got %0d/%0d want 2/1", br_cnt, miss_cnt); end
    endtask

    task automatic test_jal();
        drive(1'b1, OP_JAL, 3'b000, 32'h200, 32'h40, 32'h0, 32'h0, 1'b1, 32'h240);
        tick();
        n_chk++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL jal_hit_rv got %0h want 0", redirect_valid); end
        n_chk++; if (br_cnt !== 32'd3) begin n_fail++; $display("FAIL jal_hit_br got %0d want 3", br_cnt); end
        drive(1'b1, OP_JAL, 3'b000, 32'h200, 32'h40, 32'h0, 32'h0, 1'b1, 32'h244);
        tick();
        idle_in();
        n_chk++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h240) begin n_fail++; $display("FAIL jal_miss got rv=%0h pc=%0h want rv=1 pc=240", redirect_valid, redirect_pc); end
        n_chk++; if (br_cnt !== 32'd4 || miss_cnt !== 32'd2) begin n_fail++; $display("FAIL jal_miss_cnt got %0d/%0d want 4/2", br_cnt, miss_cnt); end
        tick();
    endtask

    task automatic test_jalr_hold_back_to_back();
        redirect_ready = 1'b0;
        drive(1'b1, OP_JALR, 3'b000, 32'h400, 32'h0, 32'h1003, 32'h0, 1'b1, 32'h1003);
        tick();
        n_chk++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h1002) begin n_fail++; $display("FAIL jalr_redir got rv=%0h pc=%0h want rv=1 pc=1002", redirect_valid, redirect_pc); end
        n_chk++; if (misalign_err !== 1'b1) begin n_fail++; $display("FAIL jalr_misalign got %0h want 1", misalign_err); end
        n_chk++; if (br_cnt !== 32'd5 || miss_cnt !== 32'd3) begin n_fail++; $display("FAIL jalr_cnt got %0d/%0d want 5/3", br_cnt, miss_cnt); end
        // wrong-path misaligned jal that would otherwise mispredict
        drive(1'b1, OP_JAL, 3'b000, 32'h500, 32'h2, 32'h0, 32'h0, 1'b0, 32'h504);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_chk++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h1002) begin n_fail++; $display("FAIL hold_pc[%0d] got rv=%0h pc=%0h want rv=1 pc=1002", i, redirect_valid, redirect_pc); end
            n_chk++; if ({flush_if_id, flush_id_ex, misalign_err} !== 3'b110) begin n_fail++; $display("FAIL hold_flags[%0d] got %0b want 110", i, {flush_if_id, flush_id_ex, misalign_err}); end
            n_chk++; if (br_cnt !== 32'd5 || miss_cnt !== 32'd3) begin n_fail++; $display("FAIL hold_cnt[%0d] got %0d/%0d want 5/3", i, br_cnt, miss_cnt); end
        end
        redirect_ready = 1'b1;
        idle_in();
        tick();
        n_chk++; if ({redirect_valid, flush_if_id, flush_id_ex} !== 3'b000) begin n_fail++; $display("FAIL hs_release got %0b want 000", {redirect_valid, flush_if_id, flush_id_ex}); end
        drive(1'b1, OP_ADD, 3'b000, 32'h300, 32'h0, 32'h0, 32'h0, 1'b1, 32'h380);
        tick();
        idle_in();
        n_chk++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h304) begin n_fail++; $display("FAIL add_redir got rv=%0h pc=%0h want rv=1 pc=304", redirect_valid, redirect_pc); end
        n_chk++; if (br_cnt !== 32'd5 || miss_cnt !== 32'd4) begin n_fail++; $display("FAIL add_cnt got %0d/%0d want 5/4", br_cnt, miss_cnt); end
        tick();
    endtask

    task automatic test_signed_and_reset_in_redir();
        drive(1'b1, OP_BRANCH, 3'b100, 32'h600, 32'h10, 32'hFFFFFFFF, 32'd1, 1'b1, 32'h610);
        tick();
        n_chk++; if (redirect_valid !== 1'b0 || br_cnt !== 32'd6) begin n_fail++; $display("FAIL blt got rv=%0h br=%0d want rv=0 br=6", redirect_valid, br_cnt); end
        drive(1'b1, OP_BRANCH, 3'b110, 32'h600, 32'h10, 32'hFFFFFFFF, 32'd1, 1'b1, 32'h610);
        tick();
        idle_in();
        n_chk++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h604) begin n_fail++; $display("FAIL bltu got rv=%0h pc=%0h want rv=1 pc=604", redirect_valid, redirect_pc); end
        n_chk++; if (br_cnt !== 32'd7 || miss_cnt !== 32'd5) begin n_fail++; $display("FAIL bltu_cnt got %0d/%0d want 7/5", br_cnt, miss_cnt); end
        redirect_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        redirect_ready = 1'b1;
        n_chk++; if ({redirect_valid, flush_if_id, flush_id_ex, misalign_err} !== 4'b0000 || redirect_pc !== 32'h0) begin n_fail++; $display("FAIL rst_redir got flags=%0b pc=%0h want 0000/0", {redirect_valid, flush_if_id, flush_id_ex, misalign_err}, redirect_pc); end
        n_chk++; if ({br_cnt, miss_cnt} !== 64'h0) begin n_fail++; $display("FAIL rst_redir_cnt got %0d/%0d want 0/0", br_cnt, miss_cnt); end
    endtask

    task automatic test_saturation();
        drive(1'b1, OP_JAL, 3'b000, 32'h800, 32'h8, 32'h0, 32'h0, 1'b1, 32'h808);
        for (int i = 0; i < 7; i++) tick();
        n_chk++; if (sm_br_cnt !== 3'd7) begin n_fail++; $display("FAIL sat_br_full got %0d want 7", sm_br_cnt); end
        tick();
        tick();
        n_chk++; if (sm_br_cnt !== 3'd7 || br_cnt !== 32'd9) begin n_fail++; $display("FAIL sat_br got %0d/%0d want 7/9", sm_br_cnt, br_cnt); end
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, OP_JAL, 3'b000, 32'h800, 32'h8, 32'h0, 32'h0, 1'b0, 32'h804);
            tick();
            idle_in();
            tick();
        end
        n_chk++; if (sm_miss_cnt !== 3'd7 || miss_cnt !== 32'd9) begin n_fail++; $display("FAIL sat_miss got %0d/%0d want 7/9", sm_miss_cnt, miss_cnt); end
        n_chk++; if (sm_br_cnt !== 3'd7 || br_cnt !== 32'd18) begin n_fail++; $display("FAIL sat_br2 got %0d/%0d want 7/18", sm_br_cnt, br_cnt); end
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst    = 1'b1;
        redirect_ready = 1'b1;
        idle_in();
        test_reset();
        test_beq_mispredict();
        test_bne_not_taken();
        test_jal();
        test_jalr_hold_back_to_back();
        test_signed_and_reset_in_redir();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
